// File: rtl/rpsc_pkg.sv
// rpsc_pkg: shared types and constant helpers for the RPSC interlock sequencer.
//   ch_state_t  - per-channel supply state (OFF, PERM, SETTLE, ON_OK, TRIP)
//   code_width  - width of a first-fault code able to hold 0..n_flt (n_flt = UV/timeout)
//   idx_width   - width of a channel index, never narrower than one bit
package rpsc_pkg;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        PERM   = 3'd1,
        SETTLE = 3'd2,
        ON_OK  = 3'd3,
        TRIP   = 3'd4
    } ch_state_t;

    function automatic int code_width(input int n_flt);
        return (n_flt < 1) ? 1 : $clog2(n_flt + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rpsc_chan_fsm.sv
// rpsc_chan_fsm: state machine and settle counters for one cascaded supply.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   tick           timebase strobe (only counted in SETTLE)
//   flt            synchronised fault bits of this channel, active-high
//   act, uok       synchronised supply-active and voltage-in-range feedback
//   up_ok          upstream supply is ON_OK (tied high for channel 0)
//   ack            fault acknowledge pulse
//   state          registered channel state
//   trip_enter     this cycle's transition goes into TRIP
//   trip_next      next state is TRIP
//   trip_code      cause of the trip being entered: lowest fault bit, else UV_CODE
module rpsc_chan_fsm
    import rpsc_pkg::*;
#(
    parameter int N_FLT         = 7,
    parameter int SETTLE_TICKS  = 128,
    parameter int TIMEOUT_TICKS = 256,
    parameter int LATCH_FAULTS  = 1,
    parameter int UV_CODE       = N_FLT,
    parameter int CW            = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [N_FLT-1:0] flt,
    input  logic             act,
    input  logic             uok,
    input  logic             up_ok,
    input  logic             ack,
    output ch_state_t        state,
    output logic             trip_enter,
    output logic             trip_next,
    output logic [CW-1:0]    trip_code
);

    localparam logic [CNT_W-1:0] GOOD_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic             AUTO_CLR  = (LATCH_FAULTS == 0);

    ch_state_t        state_r;
    ch_state_t        state_next_s;
    logic [CNT_W-1:0] good_cnt_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             uv_trip_r;
    logic             any_flt_s;

    assign any_flt_s = |flt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= OFF;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a fault wins everywhere; upstream loss sends the
    // channel OFF (not TRIP) so a cascade drop records no fault of its own.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            OFF: begin
                if (any_flt_s)  state_next_s = TRIP;
                else if (up_ok) state_next_s = PERM;
                else            state_next_s = OFF;
            end
            PERM: begin
                if (any_flt_s)   state_next_s = TRIP;
                else if (!up_ok) state_next_s = OFF;
                else if (act)    state_next_s = SETTLE;
                else             state_next_s = PERM;
            end
            SETTLE: begin
                if (any_flt_s)                                 state_next_s = TRIP;
                else if (!up_ok)                               state_next_s = OFF;
                else if (!act)                                 state_next_s = PERM;
                else if (tick && uok && good_cnt_r == GOOD_LAST) state_next_s = ON_OK;
                else if (tick && tmo_cnt_r == TMO_LAST)        state_next_s = TRIP;
                else                                           state_next_s = SETTLE;
            end
            ON_OK: begin
                if (any_flt_s)   state_next_s = TRIP;
                else if (!up_ok) state_next_s = OFF;
                else if (!uok)   state_next_s = TRIP;
                else if (!act)   state_next_s = PERM;
                else             state_next_s = ON_OK;
            end
            TRIP: begin
                // Undervoltage trips have no fault bit to watch, so they always need ack.
                if (any_flt_s)                  state_next_s = TRIP;
                else if (ack)                   state_next_s = OFF;
                else if (AUTO_CLR && !uv_trip_r) state_next_s = OFF;
                else                            state_next_s = TRIP;
            end
            default: state_next_s = OFF;
        endcase
    end

    // Trip cause: the lowest set fault bit, or UV_CODE when no bit is set.
    always_comb begin
        trip_code = CW'(UV_CODE);
        for (int i = N_FLT - 1; i >= 0; i--) begin
            trip_code = flt[i] ? CW'(i) : trip_code;
        end
    end

    assign trip_next  = (state_next_s == TRIP);
    assign trip_enter = trip_next && (state_r != TRIP);
    assign state      = state_r;

    // Settle counters: held at zero outside SETTLE, saturating inside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_r <= '0;
            tmo_cnt_r  <= '0;
        end else if (state_r != SETTLE) begin
            good_cnt_r <= '0;
            tmo_cnt_r  <= '0;
        end else if (tick) begin
            tmo_cnt_r  <= (tmo_cnt_r == CNT_MAX) ? tmo_cnt_r : tmo_cnt_r + CNT_W'(1);
            good_cnt_r <= !uok ? '0 :
                          ((good_cnt_r == CNT_MAX) ? good_cnt_r : good_cnt_r + CNT_W'(1));
        end else begin
            good_cnt_r <= good_cnt_r;
            tmo_cnt_r  <= tmo_cnt_r;
        end
    end

    // Remembers whether the current TRIP was caused by undervoltage/timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uv_trip_r <= 1'b0;
        end else if (trip_enter) begin
            uv_trip_r <= ~any_flt_s;
        end else if (!trip_next) begin
            uv_trip_r <= 1'b0;
        end else begin
            uv_trip_r <= uv_trip_r;
        end
    end

endmodule

// File: rtl/rpsc_interlock_seq.sv
// rpsc_interlock_seq: cascaded power-supply interlock sequencer.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   tick          one-clk timebase strobe
//   fault_in      N_CH*N_FLT async fault bits, channel c at [c*N_FLT +: N_FLT]
//   ps_act, u_ok  async per-channel supply-active / voltage-in-range feedback
//   ack           fault acknowledge pulse
//   on_perm       permission to switch each supply on
//   not_alarm     1 = no synchronised fault in the channel
//   ps_ok         supply confirmed OK
//   tripped       channel in TRIP
//   first_valid, first_ch, first_code   first-fault record (code N_FLT = UV/timeout)
module rpsc_interlock_seq
    import rpsc_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int N_FLT         = 7,
    parameter int SETTLE_TICKS  = 128,
    parameter int TIMEOUT_TICKS = 256,
    parameter int LATCH_FAULTS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [N_CH*N_FLT-1:0]         fault_in,
    input  logic [N_CH-1:0]               ps_act,
    input  logic [N_CH-1:0]               u_ok,
    input  logic                          ack,
    output logic [N_CH-1:0]               on_perm,
    output logic [N_CH-1:0]               not_alarm,
    output logic [N_CH-1:0]               ps_ok,
    output logic [N_CH-1:0]               tripped,
    output logic                          first_valid,
    output logic [idx_width(N_CH)-1:0]    first_ch,
    output logic [code_width(N_FLT)-1:0]  first_code
);

    localparam int CW    = code_width(N_FLT);
    localparam int IW    = idx_width(N_CH);
    localparam int CNT_W = $clog2(TIMEOUT_TICKS);

    logic [N_CH-1:0]         on_ok_s;
    logic [N_CH-1:0]         trip_enter_s;
    logic [N_CH-1:0]         trip_next_s;
    logic [N_CH-1:0][CW-1:0] trip_code_s;

    logic                    first_valid_r;
    logic [IW-1:0]           first_ch_r;
    logic [CW-1:0]           first_code_r;
    logic [IW-1:0]           pick_ch_s;
    logic [CW-1:0]           pick_code_s;

    genvar g;
    for (g = 0; g < N_CH; g++) begin : g_ch
        logic [N_FLT-1:0] flt_meta_r;
        logic [N_FLT-1:0] flt_sync_r;
        logic             act_meta_r;
        logic             act_sync_r;
        logic             uok_meta_r;
        logic             uok_sync_r;
        logic             up_ok_s;
        ch_state_t        st_s;

        // Two-flop synchroniser for this channel's asynchronous inputs.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                flt_meta_r <= '0;
                flt_sync_r <= '0;
                act_meta_r <= 1'b0;
                act_sync_r <= 1'b0;
                uok_meta_r <= 1'b0;
                uok_sync_r <= 1'b0;
            end else begin
                flt_meta_r <= fault_in[g*N_FLT +: N_FLT];
                flt_sync_r <= flt_meta_r;
                act_meta_r <= ps_act[g];
                act_sync_r <= act_meta_r;
                uok_meta_r <= u_ok[g];
                uok_sync_r <= uok_meta_r;
            end
        end

        if (g == 0) begin : g_head
            assign up_ok_s = 1'b1;
        end else begin : g_tail
            assign up_ok_s = on_ok_s[g-1];
        end

        rpsc_chan_fsm #(
            .N_FLT         (N_FLT),
            .SETTLE_TICKS  (SETTLE_TICKS),
            .TIMEOUT_TICKS (TIMEOUT_TICKS),
            .LATCH_FAULTS  (LATCH_FAULTS),
            .UV_CODE       (N_FLT),
            .CW            (CW),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (reset),
            .tick       (tick),
            .flt        (flt_sync_r),
            .act        (act_sync_r),
            .uok        (uok_sync_r),
            .up_ok      (up_ok_s),
            .ack        (ack),
            .state      (st_s),
            .trip_enter (trip_enter_s[g]),
            .trip_next  (trip_next_s[g]),
            .trip_code  (trip_code_s[g])
        );

        assign on_ok_s[g]   = (st_s == ON_OK);
        assign on_perm[g]   = (st_s == PERM) || (st_s == SETTLE) || (st_s == ON_OK);
        assign ps_ok[g]     = (st_s == ON_OK);
        assign tripped[g]   = (st_s == TRIP);
        assign not_alarm[g] = ~|flt_sync_r;
    end

    // Lowest-numbered channel entering TRIP this cycle provides the record.
    always_comb begin
        pick_ch_s   = '0;
        pick_code_s = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            pick_ch_s   = trip_enter_s[c] ? IW'(c)         : pick_ch_s;
            pick_code_s = trip_enter_s[c] ? trip_code_s[c] : pick_code_s;
        end
    end

    // First-fault record: captured on the first trip, cleared only by an ack
    // that leaves no channel in TRIP, so a trip coinciding with ack is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_valid_r <= 1'b0;
            first_ch_r    <= '0;
            first_code_r  <= '0;
        end else if (!first_valid_r && |trip_enter_s) begin
            first_valid_r <= 1'b1;
            first_ch_r    <= pick_ch_s;
            first_code_r  <= pick_code_s;
        end else if (first_valid_r && ack && !(|trip_next_s)) begin
            first_valid_r <= 1'b0;
            first_ch_r    <= '0;
            first_code_r  <= '0;
        end else begin
            first_valid_r <= first_valid_r;
            first_ch_r    <= first_ch_r;
            first_code_r  <= first_code_r;
        end
    end

    assign first_valid = first_valid_r;
    assign first_ch    = first_ch_r;
    assign first_code  = first_code_r;

endmodule

// File: tb/tb_rpsc_interlock_seq.sv
// Table-driven bench for rpsc_interlock_seq (N_CH=2, N_FLT=4, SETTLE=4, TIMEOUT=8).
// Each row drives inputs, runs reps x nclk clocks with tick/ack pulsed on the
// last clock of each group, then compares all outputs at the falling edge.
module tb_rpsc_interlock_seq;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [7:0] fault_in;
    logic [1:0] ps_act;
    logic [1:0] u_ok;
    logic       ack;
    logic [1:0] on_perm;
    logic [1:0] not_alarm;
    logic [1:0] ps_ok;
    logic [1:0] tripped;
    logic       first_valid;
    logic [0:0] first_ch;
    logic [2:0] first_code;

    int n_tests = 0;
    int n_fail  = 0;

    rpsc_interlock_seq #(
        .N_CH          (2),
        .N_FLT         (4),
        .SETTLE_TICKS  (4),
        .TIMEOUT_TICKS (8),
        .LATCH_FAULTS  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .fault_in    (fault_in),
        .ps_act      (ps_act),
        .u_ok        (u_ok),
        .ack         (ack),
        .on_perm     (on_perm),
        .not_alarm   (not_alarm),
        .ps_ok       (ps_ok),
        .tripped     (tripped),
        .first_valid (first_valid),
        .first_ch    (first_ch),
        .first_code  (first_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] flt;
        logic [1:0] act;
        logic [1:0] uok;
        logic       ak;
        logic       tk;
        int         nclk;
        int         reps;
        logic [1:0] e_perm;
        logic [1:0] e_ok;
        logic [1:0] e_trip;
        logic [1:0] e_na;
        logic       e_fv;
        logic       e_fch;
        logic [2:0] e_fcode;
    } vec_t;

    vec_t rows[$];

    task automatic add(input logic [7:0] f, input logic [1:0] a, input logic [1:0] u,
                       input logic k, input logic t, input int n, input int r,
                       input logic [1:0] ep, input logic [1:0] eo, input logic [1:0] et,
                       input logic [1:0] en, input logic fv, input logic fc,
                       input logic [2:0] fcode);
        vec_t v;
        v.flt = f; v.act = a; v.uok = u; v.ak = k; v.tk = t; v.nclk = n; v.reps = r;
        v.e_perm = ep; v.e_ok = eo; v.e_trip = et; v.e_na = en;
        v.e_fv = fv; v.e_fch = fc; v.e_fcode = fcode;
        rows.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [1:0] ep, input logic [1:0] eo,
                           input logic [1:0] et, input logic [1:0] en, input logic fv,
                           input logic fc, input logic [2:0] fcode);
        chk("on_perm",     idx, {6'd0, on_perm},    {6'd0, ep});
        chk("ps_ok",       idx, {6'd0, ps_ok},      {6'd0, eo});
        chk("tripped",     idx, {6'd0, tripped},    {6'd0, et});
        chk("not_alarm",   idx, {6'd0, not_alarm},  {6'd0, en});
        chk("first_valid", idx, {7'd0, first_valid}, {7'd0, fv});
        chk("first_ch",    idx, {7'd0, first_ch},   {7'd0, fc});
        chk("first_code",  idx, {5'd0, first_code}, {5'd0, fcode});
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            fault_in = rows[i].flt;
            ps_act   = rows[i].act;
            u_ok     = rows[i].uok;
            for (int r = 0; r < rows[i].reps; r++) begin
                repeat (rows[i].nclk - 1) @(negedge clk);
                tick = rows[i].tk;
                ack  = rows[i].ak;
                @(negedge clk);
                tick = 1'b0;
                ack  = 1'b0;
            end
            chk_all(i, rows[i].e_perm, rows[i].e_ok, rows[i].e_trip, rows[i].e_na,
                    rows[i].e_fv, rows[i].e_fch, rows[i].e_fcode);
        end
    endtask

    initial begin
        //   flt    act    uok  ak  tk  n  r  perm  ok    trip  na   fv fc code
        // power-up: ch0 permitted, settles after 4 good ticks, then ch1
        add(8'h00, 2'b00, 2'b00, 0, 0, 3, 1, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 0
        add(8'h00, 2'b01, 2'b01, 0, 1, 4, 3, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 1
        add(8'h00, 2'b01, 2'b01, 0, 1, 4, 1, 2'b01, 2'b01, 2'b00, 2'b11, 0, 0, 3'd0); // 2
        add(8'h00, 2'b11, 2'b11, 0, 1, 4, 3, 2'b11, 2'b01, 2'b00, 2'b11, 0, 0, 3'd0); // 3
        add(8'h00, 2'b11, 2'b11, 0, 1, 4, 1, 2'b11, 2'b11, 2'b00, 2'b11, 0, 0, 3'd0); // 4
        // cascade: ch0 bit2 fault, trip after two sync clocks, ch1 drops to OFF
        add(8'h04, 2'b11, 2'b11, 0, 0, 2, 1, 2'b11, 2'b11, 2'b00, 2'b10, 0, 0, 3'd0); // 5
        add(8'h04, 2'b11, 2'b11, 0, 0, 1, 1, 2'b10, 2'b10, 2'b01, 2'b10, 1, 0, 3'd2); // 6
        add(8'h04, 2'b11, 2'b11, 0, 0, 1, 1, 2'b00, 2'b00, 2'b01, 2'b10, 1, 0, 3'd2); // 7
        // ack with fault present ignored; clear fault, ack, then PERM
        add(8'h04, 2'b11, 2'b11, 1, 0, 1, 1, 2'b00, 2'b00, 2'b01, 2'b10, 1, 0, 3'd2); // 8
        add(8'h00, 2'b01, 2'b01, 0, 0, 2, 1, 2'b00, 2'b00, 2'b01, 2'b11, 1, 0, 3'd2); // 9
        add(8'h00, 2'b01, 2'b01, 1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 10
        add(8'h00, 2'b01, 2'b01, 0, 0, 1, 1, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 11
        // settle glitch restarts good count; timeout trips on the 8th tick
        add(8'h00, 2'b01, 2'b01, 0, 1, 4, 3, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 12
        add(8'h00, 2'b01, 2'b00, 0, 1, 4, 1, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 13
        add(8'h00, 2'b01, 2'b01, 0, 1, 4, 3, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 14
        add(8'h00, 2'b01, 2'b00, 0, 1, 4, 1, 2'b00, 2'b00, 2'b01, 2'b11, 1, 0, 3'd4); // 15
        // ack UV trip, then simultaneous trips ch1 bit0 + ch0 bit3
        add(8'h00, 2'b00, 2'b00, 1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 16
        add(8'h00, 2'b00, 2'b00, 0, 0, 1, 1, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 17
        add(8'h18, 2'b00, 2'b00, 0, 0, 3, 1, 2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 3'd3); // 18
        add(8'h10, 2'b00, 2'b00, 0, 0, 2, 1, 2'b00, 2'b00, 2'b11, 2'b01, 1, 0, 3'd3); // 19
        add(8'h10, 2'b00, 2'b00, 1, 0, 1, 1, 2'b00, 2'b00, 2'b10, 2'b01, 1, 0, 3'd3); // 20
        add(8'h10, 2'b00, 2'b00, 0, 0, 1, 1, 2'b01, 2'b00, 2'b10, 2'b01, 1, 0, 3'd3); // 21
        add(8'h00, 2'b00, 2'b00, 0, 0, 2, 1, 2'b01, 2'b00, 2'b10, 2'b11, 1, 0, 3'd3); // 22
        add(8'h00, 2'b00, 2'b00, 1, 0, 1, 1, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 23
        // new trip in the same cycle as ack: trip wins and is captured
        add(8'h02, 2'b00, 2'b00, 0, 0, 2, 1, 2'b01, 2'b00, 2'b00, 2'b10, 0, 0, 3'd0); // 24
        add(8'h02, 2'b00, 2'b00, 1, 0, 1, 1, 2'b00, 2'b00, 2'b01, 2'b10, 1, 0, 3'd1); // 25
        // ack clears ch0 while ch1 trips in the same cycle: record kept
        add(8'h40, 2'b00, 2'b00, 0, 0, 2, 1, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0, 3'd1); // 26
        add(8'h40, 2'b00, 2'b00, 1, 0, 1, 1, 2'b00, 2'b00, 2'b10, 2'b01, 1, 0, 3'd1); // 27
        add(8'h40, 2'b00, 2'b00, 0, 0, 1, 1, 2'b01, 2'b00, 2'b10, 2'b01, 1, 0, 3'd1); // 28
        // clear everything and get ch0 part-way through SETTLE
        add(8'h00, 2'b01, 2'b01, 0, 0, 2, 1, 2'b01, 2'b00, 2'b10, 2'b11, 1, 0, 3'd1); // 29
        add(8'h00, 2'b01, 2'b01, 1, 0, 1, 1, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 30
        add(8'h00, 2'b01, 2'b01, 0, 1, 4, 2, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 31
        // after mid-SETTLE reset: full 4 good ticks needed again
        add(8'h00, 2'b01, 2'b01, 0, 1, 4, 3, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 3'd0); // 32
        add(8'h00, 2'b01, 2'b01, 0, 1, 4, 1, 2'b01, 2'b01, 2'b00, 2'b11, 0, 0, 3'd0); // 33

        // Power-on reset with faults applied: sync flops stay 0 so not_alarm = 11.
        reset    = 1'b0;
        tick     = 1'b0;
        ack      = 1'b0;
        fault_in = 8'hFF;
        ps_act   = 2'b00;
        u_ok     = 2'b00;
        repeat (3) @(negedge clk);
        chk_all(100, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 3'd0);
        fault_in = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_rows(0, 31);

        // Asynchronous reset mid-SETTLE, off the clock edge.
        #2;
        reset    = 1'b0;
        fault_in = 8'h01;
        #1;
        chk_all(101, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 3'd0);
        repeat (3) @(negedge clk);
        chk_all(102, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 3'd0);
        fault_in = 8'h00;
        @(negedge clk);
        reset = 1'b1;

        run_rows(32, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
